// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: valid/ready command stream to pipelined single AHB-Lite transfers.
// Revision 1.0
`default_nettype none

module ahb_lite_cmd_master #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_cancel,
  output logic              busy,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase stage
  logic              a_valid;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_size;
  logic [DATA_W-1:0] a_wdata;

  // Data-phase stage (write data lives directly in hwdata)
  logic              d_valid;
  logic              d_write;

  logic              abort;
  logic              cancel_pending;
  logic              cancel_write;

  logic              accept;
  logic              err_first;
  logic              d_done;

  assign cmd_ready = (!a_valid || hready) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign err_first = d_valid && hresp && !hready;
  assign d_done    = d_valid && hready;

  assign haddr  = a_addr;
  assign htrans = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite = a_write;
  assign hsize  = a_size;
  assign hburst = 3'b000;
  assign hprot  = HPROT_VAL;
  assign busy   = a_valid || d_valid || abort;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid        <= 1'b0;
      a_write        <= 1'b0;
      a_addr         <= '0;
      a_size         <= 3'b000;
      a_wdata        <= '0;
      d_valid        <= 1'b0;
      d_write        <= 1'b0;
      hwdata         <= '0;
      abort          <= 1'b0;
      cancel_pending <= 1'b0;
      cancel_write   <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      rsp_cancel     <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_cancel <= 1'b0;

      // A command accepted during the first error cycle (A was empty) is cancelled too.
      if (err_first) begin
        abort   <= 1'b1;
        a_valid <= 1'b0;
        if (a_valid || accept) begin
          cancel_pending <= 1'b1;
          cancel_write   <= a_valid ? a_write : cmd_write;
        end
      end else if (hready) begin
        d_valid <= a_valid;
        if (a_valid) begin
          d_write <= a_write;
          hwdata  <= a_wdata;
        end
        a_valid <= accept;
        if (accept) begin
          a_write <= cmd_write;
          a_addr  <= cmd_addr;
          a_size  <= cmd_size;
          a_wdata <= cmd_wdata;
        end
      end else if (accept) begin
        a_valid <= 1'b1;
        a_write <= cmd_write;
        a_addr  <= cmd_addr;
        a_size  <= cmd_size;
        a_wdata <= cmd_wdata;
      end

      if (d_done) begin
        rsp_valid <= 1'b1;
        rsp_write <= d_write;
        rsp_err   <= hresp;
        rsp_rdata <= (d_write || hresp) ? '0 : hrdata;
        if (hresp && !cancel_pending) abort <= 1'b0;
      end else if (cancel_pending && !d_valid) begin
        rsp_valid      <= 1'b1;
        rsp_write      <= cancel_write;
        rsp_err        <= 1'b1;
        rsp_cancel     <= 1'b1;
        rsp_rdata      <= '0;
        cancel_pending <= 1'b0;
        abort          <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
